// File: rtl/hss_axil_pkg.sv
// -----------------------------------------------------------------------------
// hss_axil_pkg
// Shared definitions for the hss_axil_slave AXI4-Lite register block.
//   - AXI response codes
//   - register byte offsets and register count
//   - word-index extraction geometry
//   - write/read channel FSM state encodings
//   - helper functions for index range checks and byte-strobe merging
// Optional feature macro: HSS_AXIL_WSTRB_EN (enables byte-lane writes).
// -----------------------------------------------------------------------------
package hss_axil_pkg;

  localparam int DATA_W    = 32;
  localparam int STRB_W    = DATA_W / 8;
  localparam int NUM_REGS  = 4;

  // Word index is addr[5:2]: 16 word slots, only the first NUM_REGS exist.
  localparam int IDX_LSB   = 2;
  localparam int IDX_W     = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [5:0] REG0_OFFSET = 6'h00;
  localparam logic [5:0] REG1_OFFSET = 6'h04;
  localparam logic [5:0] REG2_OFFSET = 6'h08;
  localparam logic [5:0] REG3_OFFSET = 6'h0C;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // True when the word index addresses an implemented register.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (idx < IDX_W'(NUM_REGS));
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) begin
        res[k*8 +: 8] = new_word[k*8 +: 8];
      end else begin
        res[k*8 +: 8] = old_word[k*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage : hss_axil_pkg

// File: rtl/hss_axil_regfile.sv
// -----------------------------------------------------------------------------
// hss_axil_regfile
// Storage for the four 32-bit RW registers, write-strobe merge and read mux.
// Ports:
//   clk_i       clock (rising edge)
//   rst_i       synchronous active-high reset, clears all registers
//   wr_en_i     commit a write this cycle
//   wr_idx_i    word index of the write (out-of-range indices are ignored)
//   wr_data_i   write data
//   wr_strb_i   byte strobes (used only when HSS_AXIL_WSTRB_EN is defined)
//   rd_idx_i    word index for the combinational read mux
//   rd_data_o   current contents at rd_idx_i, zero when out of range
//   regs_o      all register contents
// Optional feature macro: HSS_AXIL_WSTRB_EN (byte-lane writes).
// -----------------------------------------------------------------------------
module hss_axil_regfile
  import hss_axil_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              wr_en_i,
  input  logic [IDX_W-1:0]                  wr_idx_i,
  input  logic [DATA_W-1:0]                 wr_data_i,
  input  logic [STRB_W-1:0]                 wr_strb_i,
  input  logic [IDX_W-1:0]                  rd_idx_i,
  output logic [DATA_W-1:0]                 rd_data_o,
  output logic [NUM_REGS-1:0][DATA_W-1:0]   regs_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic [DATA_W-1:0]               wr_word_s;

`ifdef HSS_AXIL_WSTRB_EN
  // Merge new bytes into the addressed register's current value.
  always_comb begin
    wr_word_s = merge_bytes(regs_q[wr_idx_i[1:0]], wr_data_i, wr_strb_i);
  end
`else
  logic unused_strb_s;
  assign unused_strb_s = ^wr_strb_i;

  // Full-word write: strobes are ignored.
  always_comb begin
    wr_word_s = wr_data_i;
  end
`endif

  // Next-state for the register array.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_i && idx_in_range(wr_idx_i)) begin
      regs_d[wr_idx_i[1:0]] = wr_word_s;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register array storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read mux: reflects pre-write contents during a same-cycle update.
  always_comb begin
    if (idx_in_range(rd_idx_i)) begin
      rd_data_o = regs_q[rd_idx_i[1:0]];
    end else begin
      rd_data_o = 32'h0000_0000;
    end
  end

  assign regs_o = regs_q;

endmodule : hss_axil_regfile

// File: rtl/hss_axil_slave.sv
// -----------------------------------------------------------------------------
// hss_axil_slave
// AXI4-Lite slave exposing four 32-bit RW registers at 0x0/0x4/0x8/0xC.
// Write and read channels run independent FSMs; AW and W are captured into
// holding registers in either order and committed together one edge later.
// Indices 4..15 answer SLVERR (writes discarded, reads return zero).
// Ports:
//   ACLK, ARESET               clock, synchronous active-high reset
//   S_AXI_AW*                  write address channel (AWPROT ignored)
//   S_AXI_W*                   write data channel
//   S_AXI_B*                   write response channel
//   S_AXI_AR*                  read address channel (ARPROT ignored)
//   S_AXI_R*                   read data channel
//   REG0_O..REG3_O             live register contents
// Optional feature macro: HSS_AXIL_WSTRB_EN (honour WSTRB byte lanes).
// -----------------------------------------------------------------------------
module hss_axil_slave
  import hss_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0_O,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1_O,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2_O,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3_O
);

  // Write channel state
  w_state_e             w_state_q, w_state_d;
  logic                 aw_held_q, aw_held_d;
  logic [IDX_W-1:0]     aw_idx_q,  aw_idx_d;
  logic                 w_held_q,  w_held_d;
  logic [DATA_W-1:0]    w_data_q,  w_data_d;
  logic [STRB_W-1:0]    w_strb_q,  w_strb_d;
  logic                 awready_q, awready_d;
  logic                 wready_q,  wready_d;
  logic                 bvalid_q,  bvalid_d;
  logic [1:0]           bresp_q,   bresp_d;
  logic                 wr_en_s;
  logic                 aw_hs_s;
  logic                 w_hs_s;

  // Read channel state
  r_state_e             r_state_q, r_state_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q,  rvalid_d;
  logic [DATA_W-1:0]    rdata_q,   rdata_d;
  logic [1:0]           rresp_q,   rresp_d;
  logic                 ar_hs_s;
  logic [IDX_W-1:0]     ar_idx_s;
  logic [DATA_W-1:0]    rd_data_s;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_s;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_s;
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[IDX_LSB-1:0], S_AXI_ARADDR[IDX_LSB-1:0]};

  assign aw_hs_s  = S_AXI_AWVALID && awready_q;
  assign w_hs_s   = S_AXI_WVALID  && wready_q;
  assign ar_hs_s  = S_AXI_ARVALID && arready_q;
  assign ar_idx_s = S_AXI_ARADDR[IDX_LSB +: IDX_W];

  hss_axil_regfile u_regfile (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .wr_en_i   (wr_en_s),
    .wr_idx_i  (aw_idx_q),
    .wr_data_i (w_data_q),
    .wr_strb_i (w_strb_q),
    .rd_idx_i  (ar_idx_s),
    .rd_data_o (rd_data_s),
    .regs_o    (regs_s)
  );

  // Write FSM next-state: capture AW/W independently, commit when both held.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en_s   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          // Readies are already low here, so no handshake can coincide.
          wr_en_s   = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = idx_in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          if (aw_hs_s) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[IDX_LSB +: IDX_W];
          end else begin
            aw_held_d = aw_held_q;
          end
          if (w_hs_s) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
          end else begin
            w_held_d = w_held_q;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
    // Readies are registered: they look at where the FSM and holds will be.
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Write channel registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      aw_idx_q  <= 4'h0;
      w_held_q  <= 1'b0;
      w_data_q  <= 32'h0000_0000;
      w_strb_q  <= 4'h0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read FSM next-state: sample the register mux at the AR handshake edge.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = rd_data_s;
          rresp_d   = idx_in_range(ar_idx_s) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // Read channel registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign REG0_O        = regs_s[0];
  assign REG1_O        = regs_s[1];
  assign REG2_O        = regs_s[2];
  assign REG3_O        = regs_s[3];

endmodule : hss_axil_slave

// File: tb/tb_hss_axil_slave.sv
// -----------------------------------------------------------------------------
// tb_hss_axil_slave
// Directed self-checking bench for hss_axil_slave. Inputs change on the
// falling edge or 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected values are hand-computed constants.
// Honours HSS_AXIL_WSTRB_EN for the byte-strobe expectation.
// -----------------------------------------------------------------------------
module tb_hss_axil_slave;

  logic        ACLK;
  logic        ARESET;
  logic [5:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [5:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] REG0_O, REG1_O, REG2_O, REG3_O;

  int checks_cnt = 0;
  int errors_cnt = 0;

  hss_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .REG0_O        (REG0_O),
    .REG1_O        (REG1_O),
    .REG2_O        (REG2_O),
    .REG3_O        (REG3_O)
  );

  // Free-running 10-unit clock.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Full write: AW and W presented together, optional BREADY hold-off.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold, output logic [1:0] resp);
    logic aw_done, w_done, aw_go, w_go;
    int   cnt;
    @(negedge ACLK);
    S_AXI_AWADDR = addr;  S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA  = data;  S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cnt = 0;
    while (!(aw_done && w_done) && cnt < 20) begin
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go  = S_AXI_WVALID  && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_go) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
      @(negedge ACLK);
      cnt++;
    end
    check_eq("wr_handshake", 32'(aw_done && w_done), 32'd1);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    cnt = 0;
    while (!S_AXI_BVALID && cnt < 20) begin
      @(negedge ACLK);
      cnt++;
    end
    check_eq("bvalid_seen", 32'(S_AXI_BVALID), 32'd1);
    resp = S_AXI_BRESP;
    for (int i = 0; i < hold; i++) begin
      // A second write is offered while the response is stalled.
      S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WVALID = 1'b1;
      check_eq("hold_awready", 32'(S_AXI_AWREADY), 32'd0);
      check_eq("hold_wready",  32'(S_AXI_WREADY),  32'd0);
      check_eq("hold_bvalid",  32'(S_AXI_BVALID),  32'd1);
      check_eq("hold_bresp",   32'(S_AXI_BRESP),   32'(resp));
      @(negedge ACLK);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check_eq("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
  endtask

  // Full read with N+1 RVALID latency check and optional RREADY hold-off.
  task automatic axi_read(input logic [5:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int cnt;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    cnt = 0;
    while (!S_AXI_ARREADY && cnt < 20) begin
      @(negedge ACLK);
      cnt++;
    end
    check_eq("arready_seen", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    check_eq("rvalid_n1", 32'(S_AXI_RVALID), 32'd1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    for (int i = 0; i < hold; i++) begin
      S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
      check_eq("hold_arready", 32'(S_AXI_ARREADY), 32'd0);
      check_eq("hold_rvalid",  32'(S_AXI_RVALID),  32'd1);
      check_eq("hold_rdata",   S_AXI_RDATA,        data);
      check_eq("hold_rresp",   32'(S_AXI_RRESP),   32'(resp));
      @(negedge ACLK);
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    check_eq("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
  endtask

  logic [1:0]  resp;
  logic [31:0] rdata;
  logic [31:0] exp0;
  int          bcount;

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = 6'h00; S_AXI_AWPROT = 3'b000; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 6'h00; S_AXI_ARPROT = 3'b000; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);

    // Reset state
    check_eq("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check_eq("rst_wready",  32'(S_AXI_WREADY),  32'd0);
    check_eq("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check_eq("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    check_eq("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    check_eq("rst_rdata",   S_AXI_RDATA,        32'h0);
    check_eq("rst_reg0",    REG0_O,             32'h0);
    check_eq("rst_reg3",    REG3_O,             32'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_eq("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    check_eq("post_rst_wready",  32'(S_AXI_WREADY),  32'd1);
    check_eq("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);

    // Basic write / read-back of all four registers
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, resp);
      check_eq("wr_okay", 32'(resp), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(i * 4), 0, rdata, resp);
      check_eq("rd_data", rdata, 32'(i + 1));
      check_eq("rd_okay", 32'(resp), 32'd0);
    end
    check_eq("reg0_o", REG0_O, 32'h1);
    check_eq("reg1_o", REG1_O, 32'h2);
    check_eq("reg2_o", REG2_O, 32'h3);
    check_eq("reg3_o", REG3_O, 32'h4);

    // W leads AW by three cycles
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    check_eq("skew_wready", 32'(S_AXI_WREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    check_eq("skew_wready_drop", 32'(S_AXI_WREADY), 32'd0);
    check_eq("skew_awready",     32'(S_AXI_AWREADY), 32'd1);
    check_eq("skew_no_early_b",  32'(S_AXI_BVALID), 32'd0);
    repeat (2) @(negedge ACLK);
    S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    bcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin
        bcount++;
        resp = S_AXI_BRESP;
      end
    end
    S_AXI_BREADY = 1'b0;
    check_eq("skew_single_b", 32'(bcount), 32'd1);
    check_eq("skew_bresp",    32'(resp),   32'd0);
    check_eq("skew_reg2",     REG2_O,      32'hCAFE_F00D);

    // Byte strobes
    axi_write(6'h00, 32'h0000_0001, 4'hF, 0, resp);
    axi_write(6'h00, 32'hAABB_CCDD, 4'h1, 0, resp);
`ifdef HSS_AXIL_WSTRB_EN
    exp0 = 32'h0000_00DD;
`else
    exp0 = 32'hAABB_CCDD;
`endif
    check_eq("strb_reg0", REG0_O, exp0);
    check_eq("strb_resp", 32'(resp), 32'd0);
`ifdef HSS_AXIL_WSTRB_EN
    axi_write(6'h00, 32'h1234_5678, 4'h0, 0, resp);
    check_eq("strb0_reg0", REG0_O, 32'h0000_00DD);
    check_eq("strb0_resp", 32'(resp), 32'd0);
`endif

    // Back-pressure on B and R
    axi_write(6'h0C, 32'h0000_0077, 4'hF, 5, resp);
    check_eq("bp_bresp", 32'(resp), 32'd0);
    check_eq("bp_reg3",  REG3_O, 32'h0000_0077);
    check_eq("bp_reg0",  REG0_O, exp0);
    axi_read(6'h0C, 5, rdata, resp);
    check_eq("bp_rdata", rdata, 32'h0000_0077);
    check_eq("bp_rresp", 32'(resp), 32'd0);

    // Out-of-range accesses
    axi_write(6'h10, 32'h5A5A_5A5A, 4'hF, 0, resp);
    check_eq("oor_bresp", 32'(resp), 32'd2);
    axi_read(6'h3C, 0, rdata, resp);
    check_eq("oor_rdata", rdata, 32'h0);
    check_eq("oor_rresp", 32'(resp), 32'd2);
    check_eq("oor_reg0", REG0_O, exp0);
    check_eq("oor_reg1", REG1_O, 32'h2);
    check_eq("oor_reg2", REG2_O, 32'hCAFE_F00D);
    check_eq("oor_reg3", REG3_O, 32'h0000_0077);

    // Read handshake on the same edge as a write commit to the same index
    @(negedge ACLK);
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    check_eq("coll_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    check_eq("coll_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check_eq("coll_rdata",  S_AXI_RDATA, 32'h2);
    check_eq("coll_bvalid", 32'(S_AXI_BVALID), 32'd1);
    check_eq("coll_reg1",   REG1_O, 32'h0000_0055);
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    @(negedge ACLK);

    // Reset after AW handshake with W still pending
    S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1'b1;
    check_eq("rstmid_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b1;
    S_AXI_WDATA = 32'hDEAD_BEEF;
    @(negedge ACLK);
    check_eq("rstmid_awready0", 32'(S_AXI_AWREADY), 32'd0);
    check_eq("rstmid_wready0",  32'(S_AXI_WREADY),  32'd0);
    check_eq("rstmid_arready0", 32'(S_AXI_ARREADY), 32'd0);
    check_eq("rstmid_bvalid",   32'(S_AXI_BVALID),  32'd0);
    check_eq("rstmid_bresp",    32'(S_AXI_BRESP),   32'd0);
    check_eq("rstmid_rdata",    S_AXI_RDATA,        32'h0);
    check_eq("rstmid_reg0",     REG0_O,             32'h0);
    check_eq("rstmid_reg1",     REG1_O,             32'h0);
    check_eq("rstmid_reg2",     REG2_O,             32'h0);
    check_eq("rstmid_reg3",     REG3_O,             32'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_eq("rstmid_awready1", 32'(S_AXI_AWREADY), 32'd1);
    check_eq("rstmid_wready1",  32'(S_AXI_WREADY),  32'd1);
    check_eq("rstmid_arready1", 32'(S_AXI_ARREADY), 32'd1);
    axi_write(6'h04, 32'h0000_0005, 4'hF, 0, resp);
    check_eq("rstmid_wr_okay", 32'(resp), 32'd0);
    check_eq("rstmid_wr_reg1", REG1_O, 32'h5);
    check_eq("rstmid_wr_reg0", REG0_O, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_hss_axil_slave
